alarm_trigger: RTL and testbench
================================

# alarm_trigger

Consumer side of the alarm-setting path: compares the running time-of-day against the stored alarm time (hour/min/sec produced by the alarm setting counters) and drives the alarm output. Contains a small ring/snooze state machine with per-second duration counters. Sits between the alarm-setting counters, the main clock counters and the buzzer/LED output. Stop and snooze come from pushbuttons.

## Interface
Parameters:
- RING_SEC, 60, seconds the alarm rings before auto-timeout (1..511)
- SNOOZE_SEC, 300, seconds of silence per snooze (1..511)
- SNOOZE_MAX, 3, snoozes allowed per alarm event (0..3)

Ports:
- clock  in  1  system clock (divided FPGA clock)
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- tick_sec  in  1  one-cycle strobe, once per timekeeping second
- alarm_on  in  1  arm level; 0 disarms and cancels any activity
- cur_hour  in  5  running hour, 0..23
- cur_min  in  6  running minute, 0..59
- cur_sec  in  6  running second, 0..59
- al_hour  in  5  alarm hour, 0..23
- al_min  in  6  alarm minute, 0..59
- al_sec  in  6  alarm second, 0..59
- stop_btn  in  1  stop button level (already synchronized)
- snooze_btn  in  1  snooze button level (already synchronized)
- ringing  out  1  registered; 1 while in RINGING
- buzzer  out  1  ringing AND beep phase (audible pattern)
- state  out  2  0 IDLE, 1 RINGING, 2 SNOOZE
- snooze_used  out  2  snoozes consumed in current event

## Operation
- match (comb) = alarm_on && all three time fields equal. match_d = match registered. match_rise = match && !match_d.
- stop_rise / snooze_rise = level && !previous level (previous registered).
- Counters: ring_cnt 9 bits, snz_cnt 9 bits, beep 1 bit, snooze_used 2 bits.
- Per-cycle priority: reset > !alarm_on > stop_rise > snooze_rise > tick_sec.
- IDLE: match_rise -> RINGING; ring_cnt=0, beep=1, snooze_used=0. Otherwise stay.
- RINGING:
  - !alarm_on or stop_rise -> IDLE.
  - snooze_rise and snooze_used<SNOOZE_MAX -> SNOOZE, snz_cnt=0, snooze_used+1. At SNOOZE_MAX the press is ignored (stays RINGING, counters continue).
  - tick_sec: if ring_cnt==RING_SEC-1 -> IDLE (timeout); else ring_cnt+1, beep toggles.
- SNOOZE:
  - !alarm_on or stop_rise -> IDLE. snooze_rise ignored.
  - tick_sec: if snz_cnt==SNOOZE_SEC-1 -> RINGING, ring_cnt=0, beep=1; else snz_cnt+1.
- match_rise outside IDLE ignored. The match held for a full second never retriggers (edge-based).
- Entering IDLE from any state: snooze_used is kept visible until the next trigger.
- Snooze elapsed and alarm time re-matched on the same cycle: SNOOZE->RINGING wins; match_rise is not re-evaluated.

## Timing
- Reset values: state=IDLE, ringing=0, buzzer=0, snooze_used=0, ring_cnt=0, snz_cnt=0, beep=0.
- match_d and both button-previous registers reset to 1. A match or a button held through reset does not fire.
- Trigger latency: cur_* becomes equal at cycle N -> ringing=1, buzzer=1 at N+1.
- Button latency: level rises at cycle N -> state change visible at N+1. A held button acts once.
- Timeout: exactly RING_SEC tick_sec strobes after entering RINGING -> IDLE on the edge that samples the last strobe.
- Snooze length: exactly SNOOZE_SEC tick_sec strobes.
- tick_sec coincident with stop/snooze: button wins, tick not counted.
- Reset mid-RINGING/SNOOZE: all outputs reach reset values on the next edge.

## Test plan
- Arm 07:30:00, step cur to 07:29:59 then 07:30:00 -> ringing=1, state=1, buzzer=1 one cycle later. buzzer toggles 1,0,1 on successive tick_sec. With alarm_on=0, the same stimulus -> ringing stays 0.
- RING_SEC=4, no buttons, cur held at match -> ringing drops to 0 after the 4th tick_sec. No retrigger while cur stays 07:30:00.
- SNOOZE_SEC=3: press snooze while ringing -> state=2, ringing=0, snooze_used=1 next cycle. After 3 ticks -> state=1, buzzer=1.
- SNOOZE_MAX=2: snooze twice, third press -> ignored, state stays 1, snooze_used=2. Stop press -> state=0 next cycle.
- Stop and tick_sec on the same cycle in RINGING -> IDLE. Drop alarm_on during SNOOZE -> IDLE next cycle.
- Assert reset mid-SNOOZE with snooze_btn held -> all outputs 0 next cycle. After release of reset, the held button causes no action. Re-matching later triggers normally with snooze_used=0.

Source files
------------

// File: rtl/alarm_trigger.sv
// alarm_trigger: compares running time against the stored alarm time and
// runs the ring / snooze sequence that drives the buzzer and ringing outputs.
module alarm_trigger #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned SNOOZE_MAX = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_sec,
    input  logic       alarm_on,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] al_hour,
    input  logic [5:0] al_min,
    input  logic [5:0] al_sec,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       ringing,
    output logic       buzzer,
    output logic [1:0] state,
    output logic [1:0] snooze_used
);

    localparam int unsigned CNT_W = 9;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RINGING = 2'd1;
    localparam logic [1:0] S_SNOOZE  = 2'd2;

    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SEC - 1);
    localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_SEC - 1);
    localparam logic [1:0]       SNZ_MAX   = 2'(SNOOZE_MAX);

    logic [CNT_W-1:0] ring_cnt;
    logic [CNT_W-1:0] snz_cnt;
    logic             beep;
    logic             match_d;
    logic             stop_prev;
    logic             snooze_prev;

    logic [1:0]       state_next;
    logic [CNT_W-1:0] ring_cnt_next;
    logic [CNT_W-1:0] snz_cnt_next;
    logic             beep_next;
    logic [1:0]       used_next;
    logic             ringing_next;
    logic             buzzer_next;

    logic match;
    logic match_rise;
    logic stop_rise;
    logic snooze_rise;

    // Edge detection on the time match and the two buttons.
    always_comb begin
        match = alarm_on && (cur_hour == al_hour) && (cur_min == al_min)
                && (cur_sec == al_sec);
        match_rise  = match && !match_d;
        stop_rise   = stop_btn && !stop_prev;
        snooze_rise = snooze_btn && !snooze_prev;
    end

    // State and datapath registers; edge history resets high so held inputs do not fire.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            beep        <= 1'b0;
            snooze_used <= 2'd0;
            match_d     <= 1'b1;
            stop_prev   <= 1'b1;
            snooze_prev <= 1'b1;
        end else begin
            state       <= state_next;
            ring_cnt    <= ring_cnt_next;
            snz_cnt     <= snz_cnt_next;
            beep        <= beep_next;
            snooze_used <= used_next;
            match_d     <= match;
            stop_prev   <= stop_btn;
            snooze_prev <= snooze_btn;
        end
    end

    // Next-state and counter update, priority: disarm > stop > snooze > tick.
    always_comb begin
        state_next    = state;
        ring_cnt_next = ring_cnt;
        snz_cnt_next  = snz_cnt;
        beep_next     = beep;
        used_next     = snooze_used;
        case (state)
            S_IDLE: begin
                if (match_rise) begin
                    state_next    = S_RINGING;
                    ring_cnt_next = '0;
                    beep_next     = 1'b1;
                    used_next     = 2'd0;
                end
            end
            S_RINGING: begin
                if (!alarm_on || stop_rise) begin
                    state_next = S_IDLE;
                end else if (snooze_rise && (snooze_used < SNZ_MAX)) begin
                    state_next   = S_SNOOZE;
                    snz_cnt_next = '0;
                    used_next    = snooze_used + 2'd1;
                end else if (tick_sec) begin
                    if (ring_cnt == RING_LAST) begin
                        state_next = S_IDLE;
                    end else begin
                        ring_cnt_next = ring_cnt + CNT_W'(1);
                        beep_next     = !beep;
                    end
                end
            end
            S_SNOOZE: begin
                if (!alarm_on || stop_rise) begin
                    state_next = S_IDLE;
                end else if (tick_sec) begin
                    if (snz_cnt == SNZ_LAST) begin
                        state_next    = S_RINGING;
                        ring_cnt_next = '0;
                        beep_next     = 1'b1;
                    end else begin
                        snz_cnt_next = snz_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so outputs are registered alongside it.
    always_comb begin
        ringing_next = 1'b0;
        buzzer_next  = 1'b0;
        if (state_next == S_RINGING) begin
            ringing_next = 1'b1;
            buzzer_next  = beep_next;
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ringing <= 1'b0;
            buzzer  <= 1'b0;
        end else begin
            ringing <= ringing_next;
            buzzer  <= buzzer_next;
        end
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with short ring/snooze durations.
module tb_alarm_trigger;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_sec;
    logic       alarm_on;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] al_hour;
    logic [5:0] al_min;
    logic [5:0] al_sec;
    logic       stop_btn;
    logic       snooze_btn;
    logic       ringing;
    logic       buzzer;
    logic [1:0] state;
    logic [1:0] snooze_used;

    int errors = 0;
    int checks = 0;

    alarm_trigger #(
        .RING_SEC  (4),
        .SNOOZE_SEC(3),
        .SNOOZE_MAX(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tick_sec   (tick_sec),
        .alarm_on   (alarm_on),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .al_hour    (al_hour),
        .al_min     (al_min),
        .al_sec     (al_sec),
        .stop_btn   (stop_btn),
        .snooze_btn (snooze_btn),
        .ringing    (ringing),
        .buzzer     (buzzer),
        .state      (state),
        .snooze_used(snooze_used)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        tick_sec = 1'b1;
        step();
        tick_sec = 1'b0;
    endtask

    task automatic set_cur(input bit at_match);
        if (at_match) begin
            cur_hour = 5'd7; cur_min = 6'd30; cur_sec = 6'd0;
        end else begin
            cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
        end
    endtask

    task automatic check_outs(input string tag, input int st, input int rg,
                              input int bz, input int used);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".ringing"}, int'(ringing), rg);
        check({tag, ".buzzer"}, int'(buzzer), bz);
        check({tag, ".used"}, int'(snooze_used), used);
    endtask

    // Bring cur away from the alarm, then onto it, triggering a ring.
    task automatic trigger();
        set_cur(1'b0);
        step();
        set_cur(1'b1);
        step();
    endtask

    initial begin
        reset = 1'b1; tick_sec = 1'b0; alarm_on = 1'b0;
        stop_btn = 1'b0; snooze_btn = 1'b0;
        al_hour = 5'd7; al_min = 6'd30; al_sec = 6'd0;
        set_cur(1'b0);
        step(); step();
        reset = 1'b0;
        check_outs("reset", 0, 0, 0, 0);

        // Basic trigger and beep pattern
        alarm_on = 1'b1;
        step();
        check("pre_match.ringing", int'(ringing), 0);
        set_cur(1'b1);
        step();
        check_outs("trig", 1, 1, 1, 0);
        tick();
        check("beep1.buzzer", int'(buzzer), 0);
        tick();
        check("beep2.buzzer", int'(buzzer), 1);
        tick();
        check_outs("beep3", 1, 1, 0, 0);
        tick();
        check_outs("timeout", 0, 0, 0, 0);
        step(); step(); step();
        check_outs("no_retrig", 0, 0, 0, 0);

        // Disarmed: identical stimulus does not ring
        alarm_on = 1'b0;
        trigger();
        check("disarm.ringing", int'(ringing), 0);
        step();
        check("disarm2.ringing", int'(ringing), 0);

        // Snooze cycle
        alarm_on = 1'b1;
        trigger();
        check_outs("trig2", 1, 1, 1, 0);
        snooze_btn = 1'b1;
        step();
        check_outs("snz1", 2, 0, 0, 1);
        snooze_btn = 1'b0;
        step();
        tick(); tick();
        check("snz1_wait.state", int'(state), 2);
        tick();
        check_outs("snz1_done", 1, 1, 1, 1);

        // Second snooze, then a third press is ignored at the limit
        snooze_btn = 1'b1;
        step();
        check_outs("snz2", 2, 0, 0, 2);
        snooze_btn = 1'b0;
        step();
        tick(); tick(); tick();
        check_outs("snz2_done", 1, 1, 1, 2);
        snooze_btn = 1'b1;
        step();
        check_outs("snz3_ignored", 1, 1, 1, 2);
        snooze_btn = 1'b0;
        step();
        stop_btn = 1'b1;
        step();
        check_outs("stop", 0, 0, 0, 2);
        stop_btn = 1'b0;
        step();

        // Stop coincident with tick
        trigger();
        check_outs("trig3", 1, 1, 1, 0);
        stop_btn = 1'b1; tick_sec = 1'b1;
        step();
        stop_btn = 1'b0; tick_sec = 1'b0;
        check_outs("stop_tick", 0, 0, 0, 0);
        step();

        // Disarm during snooze
        trigger();
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
        check("snz_disarm_pre.state", int'(state), 2);
        step();
        alarm_on = 1'b0;
        step();
        check_outs("disarm_snz", 0, 0, 0, 1);
        alarm_on = 1'b1;
        step();

        // Reset mid-snooze with the snooze button held
        trigger();
        snooze_btn = 1'b1;
        step();
        check("rst_snz_pre.state", int'(state), 2);
        reset = 1'b1;
        step();
        check_outs("rst_snz", 0, 0, 0, 0);
        reset = 1'b0;
        step(); step();
        check_outs("post_rst_held", 0, 0, 0, 0);
        snooze_btn = 1'b0;
        trigger();
        check_outs("retrig", 1, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
